tone_mixer: RTL

Parametrised N-channel square-wave synthesiser and mixer that replaces the single shared tone divider in the piano top level. Each channel runs its own half-period counter driven by a key/gate bit and a per-channel half-period code. A sample-rate tick snapshots all channel phases and sums them sequentially into one saturated signed sample. The sample is offered to the audio controller's write side through a valid/ready handshake, with overrun detection.

---
 rtl/tone_mixer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tone_mixer.sv
// tone_mixer: N-channel square-wave synthesiser with a sequential saturating mixer and a valid/ready sample port
//   clock        system clock
//   resetn       asynchronous reset, active HIGH (legacy name)
//   gate         per-channel key enable
//   half_period  per-channel half-period code, channel i at [i*HP_W +: HP_W]
//   sample_ready downstream can accept a sample
//   sample_out   signed saturated mixed sample
//   sample_valid sample_out holds an unconsumed sample
//   overrun      sticky flag: a tick was dropped while a sample was pending
//   active       channel currently contributes non-zero output
// Optional feature: define TONE_MIXER_ENVELOPE_EN for per-channel 8-bit attack/release gain.
module tone_mixer #(
  parameter int N_CH       = 6,
  parameter int HP_W       = 19,
  parameter int OUT_W      = 32,
  parameter int AMPLITUDE  = 110000000,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [N_CH-1:0]          gate,
  input  logic [N_CH*HP_W-1:0]     half_period,
  input  logic                     sample_ready,
  output logic signed [OUT_W-1:0]  sample_out,
  output logic                     sample_valid,
  output logic                     overrun,
  output logic [N_CH-1:0]          active
);
  localparam int AW = OUT_W + $clog2(N_CH) + 1;
  localparam int KW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int TW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam logic signed [AW-1:0] AMP  = AW'(AMPLITUDE);
  localparam logic signed [AW-1:0] MAXV = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, ACCUM, PRESENT} state_t;
  state_t state;
  logic [HP_W-1:0] hp [N_CH];
  logic [HP_W-1:0] cnt [N_CH];
  logic [N_CH-1:0] phase, keyed, run, snap_ph, snap_act;
  logic [TW-1:0] tcnt;
  logic tick;
  logic [KW-1:0] k;
  logic signed [AW-1:0] acc, contrib;
  logic [OUT_W-1:0] sat;
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hp[i] = half_period[i*HP_W +: HP_W];
      keyed[i] = gate[i] & (hp[i] != '0);
    end
  end
  assign tick = tcnt == TW'(SAMPLE_DIV - 1);
  always_comb sat = acc > MAXV ? MAXV[OUT_W-1:0] : acc < MINV ? MINV[OUT_W-1:0] : acc[OUT_W-1:0];
`ifdef TONE_MIXER_ENVELOPE_EN
  localparam int MW = OUT_W + 8;
  logic [7:0] gain [N_CH];
  logic [7:0] gain_nx [N_CH];
  logic [7:0] snap_gain [N_CH];
  logic [MW-1:0] mag;
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      gain_nx[i] = keyed[i] ? (gain[i] == 8'hff ? gain[i] : gain[i] + 8'd1)
                            : (gain[i] == 8'h00 ? gain[i] : gain[i] - 8'd1);
      // the oscillator keeps ringing through the release while gain decays
      run[i] = (hp[i] != '0) & (gate[i] | (gain[i] != 8'h00));
    end
    mag = (MW'(AMPLITUDE) * MW'(snap_gain[k])) >> 8;
    contrib = !snap_act[k] ? '0 : snap_ph[k] ? AW'(mag) : -AW'(mag);
  end
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < N_CH; i++) begin
        gain[i] <= '0;
        snap_gain[i] <= '0;
      end
      active <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (tick) gain[i] <= gain_nx[i];
        if (tick && state == IDLE) snap_gain[i] <= gain[i];
        active[i] <= (tick ? gain_nx[i] : gain[i]) != 8'h00;
      end
    end
  end
`else
  always_comb begin
    run = keyed;
    contrib = !snap_act[k] ? '0 : snap_ph[k] ? AMP : -AMP;
  end
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) active <= '0;
    else active <= keyed;
  end
`endif
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      phase <= '0;
      tcnt <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        // >= rather than == so a shortened half-period applies on the next cycle
        cnt[i] <= (!run[i] || cnt[i] >= hp[i]) ? '0 : cnt[i] + 1'b1;
        phase[i] <= (run[i] && cnt[i] >= hp[i]) ? ~phase[i] : run[i] & phase[i];
      end
    end
  end
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
      snap_ph <= '0;
      snap_act <= '0;
      acc <= '0;
      k <= '0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          snap_ph <= phase;
          snap_act <= active;
          acc <= '0;
          k <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc + contrib;
          k <= k == KW'(N_CH - 1) ? '0 : k + 1'b1;
          if (k == KW'(N_CH - 1)) state <= PRESENT;
        end
        PRESENT: begin
          if (tick) overrun <= 1'b1;
          if (!sample_valid) begin
            sample_out <= sat;
            sample_valid <= 1'b1;
          end else if (sample_ready) begin
            sample_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
